// File: rtl/sdram_port_arb.sv
// Three-port arbiter in front of the single game SDRAM channel: ROM download
// writes, 68000 reads and graphics reads, with one transaction in flight.
module sdram_port_arb #(
  parameter int AW           = 24,
  parameter int DW           = 16,
  parameter int GFX_MAX_SKIP = 4
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          rom_download,
  input  logic          req0,
  input  logic          req1,
  input  logic          req2,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [AW-1:0] addr2,
  input  logic [DW-1:0] din0,
  output logic          ack0,
  output logic          ack1,
  output logic          ack2,
  output logic          rdy0,
  output logic          rdy1,
  output logic          rdy2,
  output logic [DW-1:0] dout1,
  output logic [DW-1:0] dout2,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_din,
  input  logic          mem_ack,
  input  logic          mem_valid,
  input  logic [DW-1:0] mem_dout
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [3:0] SKIP_MAX = 4'(GFX_MAX_SKIP);

  logic [1:0]    r_state;
  logic [2:0]    r_gnt;
  logic [3:0]    r_skip;
  logic [2:0]    r_ack;
  logic [2:0]    r_rdy;
  logic [DW-1:0] r_dout1;
  logic [DW-1:0] r_dout2;
  logic          r_mem_req;
  logic [AW-1:0] r_mem_addr;
  logic          r_mem_we;
  logic [DW-1:0] r_mem_din;

  logic [2:0]    w_win;
  logic          w_cpu_gfx_ok;
  logic          w_done;
  logic [AW-1:0] w_addr;

  // Port 2 jumps ahead of port 1 once it has been passed over SKIP_MAX times.
  assign w_cpu_gfx_ok = !req0 && !rom_download;
  assign w_win[0] = req0;
  assign w_win[2] = w_cpu_gfx_ok && req2 && ((r_skip == SKIP_MAX) || !req1);
  assign w_win[1] = w_cpu_gfx_ok && req1 && !w_win[2];

  assign w_done = ((r_state == S_ISSUE) && mem_ack && mem_valid) ||
                  ((r_state == S_WAIT) && mem_valid);

  always_comb begin
    w_addr = addr1;
    if (w_win[0])      w_addr = addr0;
    else if (w_win[2]) w_addr = addr2;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_gnt      <= '0;
      r_skip     <= '0;
      r_ack      <= '0;
      r_rdy      <= '0;
      r_dout1    <= '0;
      r_dout2    <= '0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_mem_we   <= 1'b0;
      r_mem_din  <= '0;
    end else begin
      r_ack <= '0;
      r_rdy <= '0;
      case (r_state)
        S_IDLE: begin
          if (|w_win) begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= w_addr;
            r_mem_we   <= w_win[0];
            r_mem_din  <= din0;
            r_ack      <= w_win;
            r_gnt      <= w_win;
            r_state    <= S_ISSUE;
            if (w_win[2])
              r_skip <= '0;
            else if (w_win[1] && req2 && (r_skip != SKIP_MAX))
              r_skip <= r_skip + 4'd1;
          end
        end
        S_ISSUE: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_state   <= mem_valid ? S_IDLE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_valid) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      // Completion only ever follows a grant, so rdyN cannot fire without ackN.
      if (w_done) begin
        r_rdy <= r_gnt;
        r_gnt <= '0;
        if (r_gnt[1]) r_dout1 <= mem_dout;
        if (r_gnt[2]) r_dout2 <= mem_dout;
      end
    end
  end

  assign ack0     = r_ack[0];
  assign ack1     = r_ack[1];
  assign ack2     = r_ack[2];
  assign rdy0     = r_rdy[0];
  assign rdy1     = r_rdy[1];
  assign rdy2     = r_rdy[2];
  assign dout1    = r_dout1;
  assign dout2    = r_dout2;
  assign mem_req  = r_mem_req;
  assign mem_addr = r_mem_addr;
  assign mem_we   = r_mem_we;
  assign mem_din  = r_mem_din;

endmodule

// File: doc/sdram_port_arb.md
Name: sdram_port_arb

Overview:
- Shares the single game SDRAM channel among three requesters:
  - port 0: ROM download writes (ioctl path)
  - port 1: 68000 program/data reads
  - port 2: graphics (sprite/tile) fetch reads
- Sits between the requesters and the SDRAM controller's single request interface.
- Keeps exactly one transaction outstanding.
- Port 0 has absolute priority. Port 1 beats port 2, but port 2 has a bounded-starvation guarantee.

Parameters:
- AW, 24, word address width.
- DW, 16, data width.
- GFX_MAX_SKIP, 4, number of consecutive port-1 grants allowed while port 2 is pending before port 2 is forced. Valid range 1..15.

Ports:
- clk_sys  in  1  system clock (72 MHz domain).
- reset_n  in  1  asynchronous, active-low reset.
- rom_download  in  1  high while ROM download is in progress; masks ports 1 and 2.
- req0, req1, req2  in  1 each  request, level-held until the matching ack.
- addr0, addr1, addr2  in  AW each  word address.
- din0  in  DW  port-0 write data. Port 0 always writes; ports 1 and 2 always read.
- ack0, ack1, ack2  out  1 each  one-cycle pulse: request captured.
- rdy0, rdy1, rdy2  out  1 each  one-cycle pulse: transaction complete.
- dout1, dout2  out  DW each  read data, valid from the rdyN pulse and held until the next rdyN for that port.
- mem_req  out  1  request to the SDRAM controller.
- mem_addr  out  AW  address to the controller.
- mem_we  out  1  write enable to the controller.
- mem_din  out  DW  write data to the controller.
- mem_ack  in  1  controller accepted the request.
- mem_valid  in  1  read data valid / write done.
- mem_dout  in  DW  read data from the controller.

Behaviour:
- Reset (reset_n low, asynchronous): clears all outputs to 0, the state to IDLE, the grant register to none and the skip counter to 0. An outstanding controller transaction is abandoned; the controller shares this reset.
- FSM states: IDLE, ISSUE, WAIT. All outputs are registered.
- IDLE, winner selection each cycle:
  - req0 wins.
  - Otherwise, if rom_download is high, no grant.
  - Otherwise req2 wins if (req2 and (skip == GFX_MAX_SKIP or !req1)).
  - Otherwise req1 wins.
- IDLE, on a winner at edge E:
  - Latch the port's addr into mem_addr, din0 into mem_din, and set mem_we = (port 0).
  - Set mem_req = 1 and pulse ackN high for one cycle.
  - Record the grant and go to ISSUE.
  - ackN and mem_req are therefore both visible in the cycle after reqN was first sampled high.
- Skip counter update on each grant:
  - port-1 grant with req2 high: skip + 1, saturating at GFX_MAX_SKIP.
  - port-2 grant: skip = 0.
  - port-0 grant, or port-1 grant with req2 low: unchanged.
- ISSUE:
  - Hold mem_req and mem_* stable until mem_ack is sampled high, then clear mem_req.
  - If mem_valid is also high in that same cycle, complete immediately (same actions as WAIT completion) and go to IDLE.
  - Otherwise go to WAIT.
- WAIT:
  - On mem_valid, pulse rdyN for the granted port.
  - For ports 1 and 2, capture mem_dout into doutN on the same edge.
  - Then go to IDLE. mem_valid received while in IDLE is ignored.
- Request rule:
  - Requesters must drop reqN within 2 cycles of seeing ackN.
  - reqN still high when the FSM re-enters IDLE is treated as a new request.
  - Request inputs are not sampled in ISSUE or WAIT.
  - The minimum spacing between grants is 3 cycles (IDLE, ISSUE, IDLE).
- rom_download:
  - Rising mid-transaction does not abort the current transaction; masking applies from the next IDLE.
  - Port 0 requests proceed regardless of rom_download.
- Simultaneous requests: all three high gives port 0; only ports 1 and 2 high follows the skip rule.
- Tie-off guarantee: mem_req is never asserted outside ISSUE, and rdyN is never asserted without a prior ackN for the same port.

Test Plan:
- Single port-1 read: req1 at edge 0 with addr1 = 0x000123; controller acks at edge 3 and returns mem_valid with 0xBEEF at edge 6.
  -> ack1 pulses at edge 1; mem_req high over edges 1-3 with mem_addr = 0x000123 and mem_we = 0.
  -> rdy1 pulses at edge 7 with dout1 = 0xBEEF.
- Contention, req1 and req2 held continuously with GFX_MAX_SKIP = 4 -> grant sequence is 1,1,1,1,2,1,1,1,1,2.
- rom_download = 1 with req1, req2 and a port-0 write stream (din0 = 0x55AA) -> only port 0 is granted, with mem_we = 1 and mem_din = 0x55AA.
  -> When rom_download drops, port 1 is granted at the next IDLE.
- mem_ack and mem_valid high in the same cycle -> the FSM skips WAIT; rdyN follows one edge later; the next grant is possible 1 cycle after that.
- reset_n pulled low during WAIT -> all outputs are 0 immediately without a clock edge.
  -> After release, a pending req2 is granted normally with skip = 0.
- All three requests high at once -> ack0 first; then port 1 at the next IDLE (skip becomes 1); then port 2 if req1 has dropped.
